// File: rtl/delay_scan_controller.sv
// delay_scan_controller: walks masked links, scans delay for the longest zero-error eye, programs its centre
module delay_scan_controller #(
  parameter int NLINKS = 12,
  parameter int DELAY_WIDTH = 9,
  parameter int COUNTER_WIDTH = 32,
  parameter int DELAY_STEP = 8,
  parameter int DELAY_MAX = 511,
  parameter int DWELL_CYCLES = 1024,
  parameter int READY_HOLDOFF = 4,
  parameter int READY_TIMEOUT = 4096
) (
  input  logic in_clk160,
  input  logic in_clk160_aresetn,
  input  logic start,
  input  logic abort,
  input  logic [NLINKS-1:0] link_mask,
  output logic [$clog2(NLINKS)-1:0] cfg_link,
  output logic [DELAY_WIDTH-1:0] cfg_delay_in,
  output logic cfg_delay_set,
  output logic cfg_counter_reset,
  output logic cfg_latch_counters,
  input  logic delay_ready,
  input  logic [COUNTER_WIDTH-1:0] bit_counter,
  input  logic [COUNTER_WIDTH-1:0] error_counter,
  output logic busy,
  output logic done,
  output logic aborted,
  output logic [NLINKS*DELAY_WIDTH-1:0] best_delay,
  output logic [NLINKS*8-1:0] eye_width,
  output logic [NLINKS-1:0] link_fail
);
  localparam int LKW = $clog2(NLINKS);
  localparam int DW = DELAY_WIDTH;
  localparam int LW = DW + 1;
  localparam int CW = DW + 8;
  localparam int TMAX = READY_TIMEOUT > DWELL_CYCLES ? READY_TIMEOUT : DWELL_CYCLES;
  localparam int TW = $clog2(TMAX + 1);
  typedef enum logic [3:0] {
    IDLE, NEXT_LINK, SET_DELAY, WAIT_READY, CLR_CNT, DWELL,
    LATCH, WAIT_LATCH, EVAL, APPLY, WAIT_APPLY, DONE
  } state_t;
  state_t state, state_n;
  logic [NLINKS-1:0] pend;
  logic [LKW-1:0] sel;
  logic [TW-1:0] tmr;
  logic [DW-1:0] d, cur_start, best_start, new_start, centre;
  logic [LW-1:0] cur_len, best_len, new_len;
  logic [DW:0] d_step;
  logic good, ready_ok, timeout, more, abt;
  always_comb begin
    sel = '0;
    for (int i = NLINKS - 1; i >= 0; i--) sel = pend[i] ? LKW'(i) : sel;
  end
  assign abt = abort && state != IDLE;
  assign ready_ok = tmr >= TW'(READY_HOLDOFF) && delay_ready;
  assign timeout = tmr == TW'(READY_TIMEOUT - 1);
  assign good = error_counter == '0 && bit_counter != '0;
  assign new_len = good ? cur_len + LW'(1) : '0;
  assign new_start = good && cur_len == '0 ? d : cur_start;
  assign d_step = {1'b0, d} + LW'(DELAY_STEP);
  assign more = d_step <= LW'(DELAY_MAX);
  assign centre = DW'(CW'(best_start) + (((CW'(best_len) - CW'(1)) * CW'(DELAY_STEP)) >> 1));
  always_comb begin
    state_n = state;
    case (state)
      IDLE:       state_n = start ? NEXT_LINK : IDLE;
      NEXT_LINK:  state_n = |pend ? SET_DELAY : DONE;
      SET_DELAY:  state_n = WAIT_READY;
      WAIT_READY: state_n = ready_ok ? CLR_CNT : timeout ? NEXT_LINK : WAIT_READY;
      CLR_CNT:    state_n = DWELL;
      DWELL:      state_n = tmr == TW'(DWELL_CYCLES - 1) ? LATCH : DWELL;
      LATCH:      state_n = WAIT_LATCH;
      WAIT_LATCH: state_n = tmr == TW'(1) ? EVAL : WAIT_LATCH;
      EVAL:       state_n = more ? SET_DELAY : APPLY;
      APPLY:      state_n = best_len == '0 ? NEXT_LINK : WAIT_APPLY;
      WAIT_APPLY: state_n = ready_ok || timeout ? NEXT_LINK : WAIT_APPLY;
      DONE:       state_n = IDLE;
      default:    state_n = IDLE;
    endcase
    if (abt) state_n = IDLE;
  end
  always_ff @(posedge in_clk160 or negedge in_clk160_aresetn) begin
    if (!in_clk160_aresetn) begin
      state <= IDLE;
      tmr <= '0;
      pend <= '0;
      d <= '0;
      cur_len <= '0;
      best_len <= '0;
      cur_start <= '0;
      best_start <= '0;
      cfg_link <= '0;
      cfg_delay_in <= '0;
      cfg_delay_set <= 1'b0;
      cfg_counter_reset <= 1'b0;
      cfg_latch_counters <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      aborted <= 1'b0;
      best_delay <= '0;
      eye_width <= '0;
      link_fail <= '0;
    end else begin
      state <= state_n;
      tmr <= state_n == state ? tmr + TW'(1) : '0;
      cfg_delay_set <= state_n == SET_DELAY || (state == APPLY && state_n == WAIT_APPLY);
      cfg_counter_reset <= state_n == CLR_CNT;
      cfg_latch_counters <= state_n == LATCH;
      busy <= state_n != IDLE && state_n != DONE;
      done <= state_n == DONE;
      if (abt) aborted <= 1'b1;
      else case (state)
        IDLE: if (start) begin
          pend <= link_mask;
          aborted <= 1'b0;
          for (int i = 0; i < NLINKS; i++) if (link_mask[i]) begin
            best_delay[i*DW +: DW] <= '0;
            eye_width[i*8 +: 8] <= '0;
            link_fail[i] <= 1'b0;
          end
        end
        NEXT_LINK: if (|pend) begin
          cfg_link <= sel;
          pend[sel] <= 1'b0;
          d <= '0;
          cfg_delay_in <= '0;
          cur_len <= '0;
          best_len <= '0;
          cur_start <= '0;
          best_start <= '0;
        end
        WAIT_READY: if (!ready_ok && timeout) link_fail[cfg_link] <= 1'b1;
        EVAL: begin
          cur_len <= new_len;
          cur_start <= new_start;
          if (new_len > best_len) begin
            best_len <= new_len;
            best_start <= new_start;
          end
          if (more) begin
            d <= d_step[DW-1:0];
            cfg_delay_in <= d_step[DW-1:0];
          end
        end
        APPLY: if (best_len == '0) link_fail[cfg_link] <= 1'b1;
        else begin
          best_delay[int'(cfg_link)*DW +: DW] <= centre;
          eye_width[int'(cfg_link)*8 +: 8] <= best_len > LW'(255) ? 8'hff : best_len[7:0];
          cfg_delay_in <= centre;
        end
        WAIT_APPLY: if (!ready_ok && timeout) link_fail[cfg_link] <= 1'b1;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_delay_scan_controller.sv
// tb_delay_scan_controller: randomized link environment and eye-search reference model around delay_scan_controller
module tb_delay_scan_controller;
  localparam int NL = 12, DW = 9, STEP = 8, DMAX = 511, NP = DMAX / STEP + 1, TO = 64, BUDGET = 40000;
  logic in_clk160 = 1'b0, in_clk160_aresetn = 1'b0, start = 1'b0, abort = 1'b0, delay_ready = 1'b0;
  logic [NL-1:0] link_mask = '0;
  logic [3:0] cfg_link;
  logic [DW-1:0] cfg_delay_in;
  logic cfg_delay_set, cfg_counter_reset, cfg_latch_counters, busy, done, aborted;
  logic [31:0] bit_counter = '0, error_counter = '0;
  logic [NL*DW-1:0] best_delay;
  logic [NL*8-1:0] eye_width;
  logic [NL-1:0] link_fail;
  int tests = 0, fails = 0;
  logic [NP-1:0] good_map [NL];
  bit nobits [NL], stuck [NL];
  int cur_d [NL], set_cnt [NL], last_set [NL];
  int done_cnt = 0, overlap = 0, cyc = 0, rdy_wait = 0;

  always #5 in_clk160 = ~in_clk160;

  delay_scan_controller #(
    .NLINKS(NL), .DELAY_WIDTH(DW), .COUNTER_WIDTH(32), .DELAY_STEP(STEP), .DELAY_MAX(DMAX),
    .DWELL_CYCLES(4), .READY_HOLDOFF(4), .READY_TIMEOUT(TO)
  ) dut (
    .in_clk160(in_clk160), .in_clk160_aresetn(in_clk160_aresetn), .start(start), .abort(abort),
    .link_mask(link_mask), .cfg_link(cfg_link), .cfg_delay_in(cfg_delay_in), .cfg_delay_set(cfg_delay_set),
    .cfg_counter_reset(cfg_counter_reset), .cfg_latch_counters(cfg_latch_counters), .delay_ready(delay_ready),
    .bit_counter(bit_counter), .error_counter(error_counter), .busy(busy), .done(done), .aborted(aborted),
    .best_delay(best_delay), .eye_width(eye_width), .link_fail(link_fail)
  );

  // Link array model: applies delays, answers ready after a random settle, latches counters per eye map
  always @(negedge in_clk160) begin
    cyc++;
    if (int'(cfg_delay_set) + int'(cfg_counter_reset) + int'(cfg_latch_counters) > 1) overlap++;
    if (done) done_cnt++;
    if (cfg_delay_set) begin
      cur_d[cfg_link] = int'(cfg_delay_in);
      set_cnt[cfg_link]++;
      last_set[cfg_link] = int'(cfg_delay_in);
      delay_ready = 1'b0;
      rdy_wait = $urandom_range(0, 10);
    end else if (rdy_wait > 0) rdy_wait--;
    else delay_ready = !stuck[cfg_link];
    if (cfg_latch_counters) begin
      if (nobits[cfg_link]) begin
        bit_counter = '0;
        error_counter = '0;
      end else if (good_map[cfg_link][cur_d[cfg_link] / STEP]) begin
        bit_counter = $urandom | 32'h1;
        error_counter = '0;
      end else begin
        bit_counter = $urandom_range(1, 1000);
        error_counter = $urandom_range(1, 100);
      end
    end
  end

  function automatic logic [NP-1:0] win(input int lo, input int hi);
    logic [NP-1:0] w;
    for (int p = 0; p < NP; p++) w[p] = p * STEP >= lo && p * STEP <= hi;
    return w;
  endfunction

  // Expected result: earliest longest run of good points, centre halfway across it
  function automatic void model(input int l, output int bd, output int ew, output bit lf);
    int bs, bn, n;
    bs = 0;
    bn = 0;
    if (!stuck[l] && !nobits[l])
      for (int s = 0; s < NP; s++) begin
        n = 0;
        while (s + n < NP && good_map[l][s + n]) n++;
        if (n > bn) begin
          bn = n;
          bs = s;
        end
      end
    lf = bn == 0;
    ew = bn > 255 ? 255 : bn;
    bd = bn == 0 ? 0 : (bs * STEP + ((bn - 1) * STEP) / 2) % (1 << DW);
  endfunction

  task automatic set_link(input int l, input logic [NP-1:0] m, input bit nb, input bit st);
    good_map[l] = m;
    nobits[l] = nb;
    stuck[l] = st;
  endtask

  task automatic clear_logs();
    for (int l = 0; l < NL; l++) begin
      set_cnt[l] = 0;
      last_set[l] = -1;
    end
    done_cnt = 0;
  endtask

  task automatic pulse_start(input logic [NL-1:0] m);
    @(negedge in_clk160);
    link_mask = m;
    start = 1'b1;
    @(negedge in_clk160);
    start = 1'b0;
  endtask

  task automatic wait_done(output bit ok);
    int n = 0;
    while (n < BUDGET && !done) begin
      @(negedge in_clk160);
      n++;
    end
    ok = done;
    repeat (3) @(negedge in_clk160);
  endtask

  task automatic test_reset;
    for (int l = 0; l < NL; l++) set_link(l, '0, 1'b0, 1'b0);
    repeat (3) @(negedge in_clk160);
    tests++;
    if ({busy, done, aborted, cfg_delay_set, cfg_counter_reset, cfg_latch_counters} !== 6'b0) begin
      $display("FAIL reset_ctl got %b exp 000000", {busy, done, aborted, cfg_delay_set, cfg_counter_reset, cfg_latch_counters});
      fails++;
    end
    tests++;
    if (best_delay !== '0 || eye_width !== '0 || link_fail !== '0 || cfg_link !== '0 || cfg_delay_in !== '0) begin
      $display("FAIL reset_data got bd=%h ew=%h lf=%h exp 0", best_delay, eye_width, link_fail);
      fails++;
    end
    in_clk160_aresetn = 1'b1;
  endtask

  task automatic test_empty_mask;
    clear_logs();
    pulse_start('0);
    tests++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      $display("FAIL empty_c1 got busy=%b done=%b exp busy=1 done=0", busy, done);
      fails++;
    end
    @(negedge in_clk160);
    tests++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      $display("FAIL empty_c2 got busy=%b done=%b exp busy=0 done=1", busy, done);
      fails++;
    end
    @(negedge in_clk160);
    tests++;
    if (done !== 1'b0) begin
      $display("FAIL empty_c3 got done=%b exp 0", done);
      fails++;
    end
  endtask

  task automatic test_window;
    bit ok;
    set_link(0, win(96, 200), 1'b0, 1'b0);
    clear_logs();
    pulse_start(12'h001);
    wait_done(ok);
    tests++;
    if (!ok) begin
      $display("FAIL win_done got timeout exp done");
      fails++;
    end
    tests++;
    if (best_delay[0 +: DW] !== 9'd148 || eye_width[0 +: 8] !== 8'd14 || link_fail !== '0) begin
      $display("FAIL win_result got bd=%0d ew=%0d lf=%h exp bd=148 ew=14 lf=0", best_delay[0 +: DW], eye_width[0 +: 8], link_fail);
      fails++;
    end
    tests++;
    if (last_set[0] !== 148 || set_cnt[0] !== NP + 1 || done_cnt !== 1) begin
      $display("FAIL win_apply got last=%0d sets=%0d dones=%0d exp last=148 sets=%0d dones=1", last_set[0], set_cnt[0], done_cnt, NP + 1);
      fails++;
    end
  endtask

  task automatic test_tie;
    bit ok;
    set_link(0, win(16, 48) | win(304, 336), 1'b0, 1'b0);
    clear_logs();
    pulse_start(12'h001);
    wait_done(ok);
    tests++;
    if (!ok || best_delay[0 +: DW] !== 9'd32 || eye_width[0 +: 8] !== 8'd5 || link_fail[0] !== 1'b0) begin
      $display("FAIL tie got ok=%0d bd=%0d ew=%0d lf=%b exp bd=32 ew=5 lf=0", ok, best_delay[0 +: DW], eye_width[0 +: 8], link_fail[0]);
      fails++;
    end
  endtask

  task automatic test_two_links;
    bit ok;
    set_link(0, '0, 1'b0, 1'b0);
    set_link(2, '1, 1'b0, 1'b0);
    clear_logs();
    pulse_start(12'h005);
    wait_done(ok);
    tests++;
    if (!ok || link_fail !== 12'h001 || best_delay[0 +: DW] !== '0) begin
      $display("FAIL two_fail got ok=%0d lf=%h bd0=%0d exp lf=001 bd0=0", ok, link_fail, best_delay[0 +: DW]);
      fails++;
    end
    tests++;
    if (best_delay[2*DW +: DW] !== 9'd252 || eye_width[16 +: 8] !== 8'd64) begin
      $display("FAIL two_link2 got bd=%0d ew=%0d exp bd=252 ew=64", best_delay[2*DW +: DW], eye_width[16 +: 8]);
      fails++;
    end
    tests++;
    if (set_cnt[1] !== 0 || set_cnt[0] !== NP) begin
      $display("FAIL two_sets got link1=%0d link0=%0d exp link1=0 link0=%0d", set_cnt[1], set_cnt[0], NP);
      fails++;
    end
  endtask

  task automatic test_no_bits;
    bit ok;
    set_link(1, '1, 1'b1, 1'b0);
    clear_logs();
    pulse_start(12'h002);
    wait_done(ok);
    tests++;
    if (!ok || link_fail[1] !== 1'b1 || best_delay[DW +: DW] !== '0 || set_cnt[1] !== NP) begin
      $display("FAIL nobits got ok=%0d lf=%b bd=%0d sets=%0d exp lf=1 bd=0 sets=%0d", ok, link_fail[1], best_delay[DW +: DW], set_cnt[1], NP);
      fails++;
    end
  endtask

  task automatic test_timeout;
    bit ok, lf;
    int t0, n, bd, ew;
    set_link(3, '1, 1'b0, 1'b1);
    set_link(4, {$urandom, $urandom} | {$urandom, $urandom}, 1'b0, 1'b0);
    clear_logs();
    pulse_start(12'h018);
    n = 0;
    while (n < BUDGET && !(cfg_delay_set && cfg_link == 4'd3)) begin
      @(negedge in_clk160);
      n++;
    end
    t0 = cyc;
    while (n < BUDGET && cfg_link != 4'd4) begin
      @(negedge in_clk160);
      n++;
    end
    tests++;
    if (cyc - t0 < TO || cyc - t0 > TO + 4) begin
      $display("FAIL tmo_time got %0d cycles exp %0d..%0d", cyc - t0, TO, TO + 4);
      fails++;
    end
    wait_done(ok);
    tests++;
    if (!ok || link_fail[3] !== 1'b1 || set_cnt[3] !== 1 || best_delay[3*DW +: DW] !== '0) begin
      $display("FAIL tmo_link3 got ok=%0d lf=%b sets=%0d bd=%0d exp lf=1 sets=1 bd=0", ok, link_fail[3], set_cnt[3], best_delay[3*DW +: DW]);
      fails++;
    end
    model(4, bd, ew, lf);
    tests++;
    if (int'(best_delay[4*DW +: DW]) !== bd || int'(eye_width[32 +: 8]) !== ew || link_fail[4] !== lf) begin
      $display("FAIL tmo_link4 got bd=%0d ew=%0d lf=%b exp bd=%0d ew=%0d lf=%b", best_delay[4*DW +: DW], eye_width[32 +: 8], link_fail[4], bd, ew, lf);
      fails++;
    end
  endtask

  task automatic test_abort;
    bit lf;
    int n, bd, ew;
    set_link(1, win(200, 400), 1'b0, 1'b0);
    set_link(2, '1, 1'b0, 1'b0);
    clear_logs();
    pulse_start(12'h006);
    n = 0;
    while (n < BUDGET && !(cfg_counter_reset && cfg_link == 4'd2)) begin
      @(negedge in_clk160);
      n++;
    end
    tests++;
    if (n >= BUDGET) begin
      $display("FAIL abort_reach got timeout exp link2 dwell");
      fails++;
    end
    @(negedge in_clk160);
    abort = 1'b1;
    @(negedge in_clk160);
    abort = 1'b0;
    tests++;
    if (busy !== 1'b0 || aborted !== 1'b1 || {cfg_delay_set, cfg_counter_reset, cfg_latch_counters} !== 3'b0) begin
      $display("FAIL abort_now got busy=%b aborted=%b pulses=%b exp busy=0 aborted=1 pulses=000", busy, aborted, {cfg_delay_set, cfg_counter_reset, cfg_latch_counters});
      fails++;
    end
    repeat (20) @(negedge in_clk160);
    tests++;
    if (done_cnt !== 0 || busy !== 1'b0 || aborted !== 1'b1) begin
      $display("FAIL abort_after got dones=%0d busy=%b aborted=%b exp 0 0 1", done_cnt, busy, aborted);
      fails++;
    end
    model(1, bd, ew, lf);
    tests++;
    if (int'(best_delay[DW +: DW]) !== bd || int'(eye_width[8 +: 8]) !== ew || link_fail[1] !== lf) begin
      $display("FAIL abort_link1 got bd=%0d ew=%0d lf=%b exp bd=%0d ew=%0d lf=%b", best_delay[DW +: DW], eye_width[8 +: 8], link_fail[1], bd, ew, lf);
      fails++;
    end
    tests++;
    if (best_delay[2*DW +: DW] !== '0 || eye_width[16 +: 8] !== '0 || link_fail[2] !== 1'b0) begin
      $display("FAIL abort_link2 got bd=%0d ew=%0d lf=%b exp 0 0 0", best_delay[2*DW +: DW], eye_width[16 +: 8], link_fail[2]);
      fails++;
    end
  endtask

  task automatic test_random;
    bit ok, lf;
    int bd, ew;
    logic [NL-1:0] m;
    for (int it = 0; it < 3; it++) begin
      m = (NL'(1) << $urandom_range(0, NL - 1)) | (NL'(1) << $urandom_range(0, NL - 1));
      for (int l = 0; l < NL; l++)
        set_link(l, {$urandom, $urandom} | {$urandom, $urandom}, $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0);
      clear_logs();
      pulse_start(m);
      tests++;
      if (aborted !== 1'b0 || busy !== 1'b1) begin
        $display("FAIL rnd_start got aborted=%b busy=%b exp 0 1", aborted, busy);
        fails++;
      end
      wait_done(ok);
      tests++;
      if (!ok || done_cnt !== 1) begin
        $display("FAIL rnd_done got ok=%0d dones=%0d exp 1 1", ok, done_cnt);
        fails++;
      end
      for (int l = 0; l < NL; l++) if (m[l]) begin
        model(l, bd, ew, lf);
        tests++;
        if (int'(best_delay[l*DW +: DW]) !== bd || int'(eye_width[l*8 +: 8]) !== ew || link_fail[l] !== lf) begin
          $display("FAIL rnd_link%0d got bd=%0d ew=%0d lf=%b exp bd=%0d ew=%0d lf=%b", l, best_delay[l*DW +: DW], eye_width[l*8 +: 8], link_fail[l], bd, ew, lf);
          fails++;
        end
      end
    end
  endtask

  task automatic test_back_to_back;
    bit ok, lf;
    int bd, ew;
    set_link(0, {$urandom, $urandom} | {$urandom, $urandom}, 1'b0, 1'b0);
    set_link(11, {$urandom, $urandom} | {$urandom, $urandom}, 1'b0, 1'b0);
    clear_logs();
    pulse_start(12'h001);
    repeat (50) @(negedge in_clk160);
    pulse_start(12'h800);
    wait_done(ok);
    model(0, bd, ew, lf);
    tests++;
    if (!ok || set_cnt[11] !== 0 || done_cnt !== 1) begin
      $display("FAIL b2b_ignore got ok=%0d sets11=%0d dones=%0d exp 1 0 1", ok, set_cnt[11], done_cnt);
      fails++;
    end
    tests++;
    if (int'(best_delay[0 +: DW]) !== bd || int'(eye_width[0 +: 8]) !== ew || link_fail[0] !== lf) begin
      $display("FAIL b2b_link0 got bd=%0d ew=%0d lf=%b exp bd=%0d ew=%0d lf=%b", best_delay[0 +: DW], eye_width[0 +: 8], link_fail[0], bd, ew, lf);
      fails++;
    end
    clear_logs();
    pulse_start(12'h800);
    wait_done(ok);
    model(11, bd, ew, lf);
    tests++;
    if (!ok || int'(best_delay[11*DW +: DW]) !== bd || int'(eye_width[88 +: 8]) !== ew || link_fail[11] !== lf) begin
      $display("FAIL b2b_link11 got ok=%0d bd=%0d ew=%0d lf=%b exp bd=%0d ew=%0d lf=%b", ok, best_delay[11*DW +: DW], eye_width[88 +: 8], link_fail[11], bd, ew, lf);
      fails++;
    end
  endtask

  task automatic test_exclusive;
    tests++;
    if (overlap !== 0) begin
      $display("FAIL pulse_excl got %0d overlapping cycles exp 0", overlap);
      fails++;
    end
  endtask

  initial begin
    test_reset();
    test_empty_mask();
    test_window();
    test_tie();
    test_two_links();
    test_no_bits();
    test_timeout();
    test_abort();
    test_random();
    test_back_to_back();
    test_exclusive();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
